// File: rtl/lsu_pkg.sv
// Shared load/store encodings: RV32I size/sign codes, FSM states
// and the access legality check used at accept and response time.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } lsu_state_e;

  function automatic logic lsu_err(
    input logic       we,
    input logic [2:0] f3,
    input logic [1:0] a
  );
    logic bad_f3;
    logic mis;
    if (we)
      bad_f3 = !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
    else
      bad_f3 = (f3 == 3'b011) || (f3 == 3'b110) ||
               (f3 == 3'b111);
    mis = ((f3[1:0] == 2'b01) && a[0]) ||
          ((f3[1:0] == 2'b10) && (a != 2'b00));
    return bad_f3 || mis;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane datapath: store merge into a read word and
// load lane select with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [15:0] wdata,
  output logic [31:0] merged,
  output logic [31:0] loaded
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b      = word[{addr_lo, 3'b000} +: 8];
    h      = addr_lo[1] ? word[31:16] : word[15:0];
    merged = word;
    if (funct3[1:0] == 2'b00)
      merged[{addr_lo, 3'b000} +: 8] = wdata[7:0];
    else if (funct3[1:0] == 2'b01)
      merged[{addr_lo[1], 4'b0000} +: 16] = wdata;
  end

  always_comb begin
    loaded = word;
    unique case (1'b1)
      funct3 == F3_B:  loaded = {{24{b[7]}}, b};
      funct3 == F3_H:  loaded = {{16{h[15]}}, h};
      funct3 == F3_BU: loaded = {24'h0, b};
      funct3 == F3_HU: loaded = {16'h0, h};
      default:         loaded = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle RV32I load/store unit: one access at a time,
// read-modify-write for sub-word stores.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  lsu_state_e state, state_nx;

  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       word_q;
  logic              err_q;
  logic              req_err;
  logic [31:0]       merged;
  logic [31:0]       loaded;

  // Upper address bits wrap; they never reach memory.
  logic unused_addr;
  assign unused_addr = ^req_addr[31:ADDR_W+2];

  assign req_err  = lsu_err(req_we, req_funct3, req_addr[1:0]);
  assign err_q    = lsu_err(we_q, f3_q, addr_q[1:0]);
  assign mem_addr = addr_q[ADDR_W+1:2];

  lsu_align u_align (
    .word    (word_q),
    .addr_lo (addr_q[1:0]),
    .funct3  (f3_q),
    .wdata   (wdata_q[15:0]),
    .merged  (merged),
    .loaded  (loaded)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:
        if (req_valid) begin
          if (req_err)
            state_nx = S_RESP;
          else if (req_we && req_funct3 == F3_W)
            state_nx = S_WRITE;
          else
            state_nx = S_READ;
        end
      S_READ:  state_nx = we_q ? S_WRITE : S_RESP;
      S_WRITE: state_nx = S_RESP;
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == S_IDLE);
    mem_we    = (state == S_WRITE);
    rsp_valid = (state == S_RESP);
    rsp_err   = 1'b0;
    rsp_rdata = 32'h0;
    mem_wdata = 32'h0;
    if (state == S_WRITE)
      mem_wdata = (f3_q == F3_W) ? wdata_q : merged;
    if (state == S_RESP) begin
      rsp_err = err_q;
      if (!we_q && !err_q)
        rsp_rdata = loaded;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      word_q  <= 32'h0;
    end else begin
      if (state == S_IDLE && req_valid) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr[ADDR_W+1:0];
        wdata_q <= req_wdata;
      end
      if (state == S_READ)
        word_q <= mem_rdata;
    end
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning the word-address width driven to the data memory (2^ADDR_W 32-bit words).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on posedge.
REQ-003 The block SHALL have port rst_n, input, 1, the reset; asynchronous, active-low.
REQ-004 The block SHALL have port req_valid, input, 1, meaning the pipeline presents an access this cycle.
REQ-005 The block SHALL have port req_ready, output, 1, meaning the unit accepts a request this cycle.
REQ-006 The block SHALL have port req_we, input, 1, meaning 1=store, 0=load.
REQ-007 The block SHALL have port req_funct3, input, 3, giving RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 The block SHALL have port req_addr, input, 32, the byte address.
REQ-009 The block SHALL have port req_wdata, input, 32, the store data, LSB-aligned.
REQ-010 The block SHALL have port rsp_valid, output, 1, a one-cycle completion pulse.
REQ-011 The block SHALL have port rsp_rdata, output, 32, the extended load data (0 for stores and errors).
REQ-012 The block SHALL have port rsp_err, output, 1, flagging a misaligned or illegal funct3 access; valid with rsp_valid.
REQ-013 The block SHALL have port mem_we, output, 1, the memory write enable; the memory samples it on negedge clk.
REQ-014 The block SHALL have port mem_addr, output, ADDR_W, the word address, equal to req_addr[ADDR_W+1:2] as latched.
REQ-015 The block SHALL have port mem_wdata, output, 32, the full word to write.
REQ-016 The block SHALL have port mem_rdata, input, 32, the combinational read data for mem_addr.

Function
REQ-017 The FSM SHALL have states IDLE, READ, WRITE, RESP; req_ready SHALL be 1 only in IDLE.
REQ-018 In IDLE, req_valid=1 SHALL latch we/funct3/addr/wdata and transition as follows:
- error -> RESP
- LW/LB/LH/LBU/LHU/SB/SH -> READ
- SW -> WRITE
REQ-019 The error condition SHALL be any of: halfword with addr[0]=1; word with addr[1:0]!=0; load funct3 in {011,110,111}; store funct3 not in {000,001,010}.
REQ-020 READ SHALL last exactly one cycle with mem_we=0, capturing mem_rdata into a word register at the closing posedge; it SHALL then go to RESP for loads and WRITE for stores.
REQ-021 For SB, WRITE SHALL replace byte lane addr[1:0] of the captured word with wdata[7:0]; for SH, it SHALL replace halfword lane addr[1] with wdata[15:0]; all other bits SHALL be unchanged.
REQ-022 For SW, WRITE SHALL drive mem_wdata=wdata.
REQ-023 WRITE SHALL last exactly one cycle with mem_we=1; mem_we SHALL be 0 in every other state.
REQ-024 RESP SHALL assert rsp_valid for one cycle, then return to IDLE. A new request SHALL be accepted in the following IDLE cycle, never in RESP.
REQ-025 Load extension SHALL be: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW returns the word unchanged.
REQ-026 Latency, from the accepting cycle to the rsp_valid cycle, SHALL be:
- LW/loads: 2
- SW: 2
- SB/SH: 3
- error: 1
REQ-027 Upper address bits [31:ADDR_W+2] SHALL be ignored (address wrap-around); there is no out-of-range error.
REQ-028 mem_addr SHALL be held constant from READ through WRITE of one access.

Reset
REQ-029 rst_n=0 SHALL immediately force:
- state=IDLE
- mem_we=0
- rsp_valid=0
- rsp_err=0
- rsp_rdata=0
- mem_addr=0
- mem_wdata=0
- latched request=0
REQ-030 Reset during WRITE SHALL deassert mem_we asynchronously, before the negedge if rst_n falls in the high phase; the aborted access SHALL produce no response.
REQ-031 req_ready SHALL be 1 in the first cycle after rst_n rises.

Structure
REQ-032 The funct3 encodings and FSM state encodings SHALL live in shared package lsu_pkg.
REQ-033 Byte-lane merge and load extension SHALL be one combinational sub-module, lsu_align, reused for both paths.

Verification
REQ-034 Scenario: memory word 5 = 0x8081_8283; LB addr 0x15 -> rsp_rdata 0xFFFF_FF82 at accept+2, rsp_err=0.
REQ-035 Scenario: same word, LHU addr 0x16 -> rsp_rdata 0x0000_8081; LW addr 0x14 -> 0x8081_8283.
REQ-036 Scenario: word 3 = 0x1122_3344; SB addr 0x0D data 0xAB -> one mem_we cycle at accept+2 writing 0x1122_AB44; a subsequent LW returns 0x1122_AB44.
REQ-037 Scenario: SH addr 0x0B -> rsp_err=1 at accept+1, no mem_we pulse, memory unchanged.
REQ-038 Scenario: SW addr 0x400 data 0xDEAD_BEEF -> writes word 0 (wrap); assert rst_n=0 during the WRITE of a following SB -> mem_we drops at once, no rsp_valid, target word unchanged.
REQ-039 Scenario: back-to-back req_valid held high -> req_ready pulses only in IDLE, and each request receives exactly one rsp_valid, in order.
